// File: rtl/model_fetch_controller.sv
// model_fetch_controller
// Walks the triangles of one model. For each triangle it reads the three vertex
// ids from the index ROM. For each vertex it then reads the position and the
// normal, and offers the vertex downstream with a valid/ready handshake.
// All ROMs are read-only with a fixed READ_LATENCY and have no handshake.
module model_fetch_controller #(
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [11:0] triangle_count_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [11:0] index_id_out,
    input  logic [35:0] index_in,
    output logic [11:0] position_id_out,
    input  logic [95:0] position_in,
    output logic [11:0] normal_id_out,
    input  logic [95:0] normal_in,
    output logic        vertex_valid_out,
    input  logic        vertex_ready_in,
    output logic [95:0] vertex_position_out,
    output logic [95:0] vertex_normal_out,
    output logic [1:0]  vertex_corner_out,
    output logic        vertex_last_out
);

    localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IDX_WAIT,
        S_VTX_REQ,
        S_VTX_WAIT,
        S_VTX_OUT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [11:0]       count_q;
    logic [11:0]       tri_q;
    logic [1:0]        corner_q;
    logic [2:0][11:0]  vid_q;
    logic [WAIT_W-1:0] wait_q;

    logic        accept;
    logic        wait_last;
    logic        handshake;
    logic        last_tri;
    logic [12:0] tri_next;
    logic [11:0] cur_vid;

    // The triangle counter is compared using 13 bits, so it cannot wrap at count=4095.
    assign tri_next  = {1'b0, tri_q} + 13'd1;
    assign last_tri  = (tri_next == {1'b0, count_q});
    assign wait_last = (wait_q == WAIT_W'(READ_LATENCY - 1));
    assign handshake = (state == S_VTX_OUT) && vertex_ready_in;

    // State register.
    always_ff @(posedge clk_in) begin
        // NOTE: registers use non-blocking assignments. Every flop then samples
        // the values from before the edge, whatever order the statements are in.
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and acceptance of a start.
    always_comb begin
        // NOTE: defaults come first, so a path that does not assign a signal
        // cannot infer a latch.
        next_state = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_in) begin
                    accept     = 1'b1;
                    next_state = (triangle_count_in == 12'd0) ? S_DONE : S_IDX_WAIT;
                end
            end
            S_IDX_WAIT: if (wait_last) next_state = S_VTX_REQ;
            S_VTX_REQ:  next_state = S_VTX_WAIT;
            S_VTX_WAIT: if (wait_last) next_state = S_VTX_OUT;
            S_VTX_OUT: begin
                if (vertex_ready_in) begin
                    if (corner_q != 2'd2) next_state = S_VTX_REQ;
                    else if (last_tri)    next_state = S_DONE;
                    else                  next_state = S_IDX_WAIT;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output decode. The index address runs one triangle ahead during the final
    // corner. It is therefore already on the ROM address a cycle before IDX_WAIT,
    // which gives the ROM its full latency.
    always_comb begin
        busy_out     = (state != S_IDLE);
        done_out     = (state == S_DONE);
        index_id_out = tri_q;
        if (state == S_IDLE) begin
            index_id_out = 12'd0;
        end else if ((state == S_VTX_OUT) && (corner_q == 2'd2)) begin
            index_id_out = tri_next[11:0];
        end
        case (corner_q)
            2'd0:    cur_vid = vid_q[0];
            2'd1:    cur_vid = vid_q[1];
            default: cur_vid = vid_q[2];
        endcase
        position_id_out   = cur_vid;
        normal_id_out     = cur_vid;
        vertex_corner_out = corner_q;
        vertex_last_out   = vertex_valid_out && (corner_q == 2'd2) && last_tri;
    end

    // Datapath: counters, latched vertex ids, the read wait counter and the output vertex.
    always_ff @(posedge clk_in) begin
        // NOTE: every register here is reset, including the vertex-id and data
        // registers. An aborted fetch then leaves all the outputs at zero.
        if (rst_in) begin
            count_q             <= '0;
            tri_q               <= '0;
            corner_q            <= '0;
            vid_q               <= '0;
            wait_q              <= '0;
            vertex_valid_out    <= 1'b0;
            vertex_position_out <= '0;
            vertex_normal_out   <= '0;
        end else begin
            if (accept) begin
                count_q <= triangle_count_in;
                tri_q   <= '0;
            end

            if (((state == S_IDX_WAIT) || (state == S_VTX_WAIT)) && !wait_last) begin
                wait_q <= wait_q + WAIT_W'(1);
            end else begin
                wait_q <= '0;
            end

            if ((state == S_IDX_WAIT) && wait_last) begin
                vid_q    <= index_in;
                corner_q <= 2'd0;
            end

            if ((state == S_VTX_WAIT) && wait_last) begin
                vertex_position_out <= position_in;
                vertex_normal_out   <= normal_in;
                vertex_valid_out    <= 1'b1;
            end

            if (handshake) begin
                vertex_valid_out <= 1'b0;
                if (corner_q != 2'd2) begin
                    corner_q <= corner_q + 2'd1;
                end else if (!last_tri) begin
                    tri_q <= tri_next[11:0];
                end
            end
        end
    end

endmodule
